// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: state encodings seen by the
// timer and display logic, plus the digit width.
package lock_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        WAITING  = 2'b00,
        EDITING  = 2'b01,
        UNLOCKED = 2'b10,
        ALARMING = 2'b11
    } lock_state_e;

endpackage

// File: rtl/lock_controller_edge_detect.sv
// Rising-edge detector for a synchronous level button. The rise is masked for
// the first cycle after reset so a button held through reset release is not
// mistaken for a fresh press.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic r_in_q;
    logic r_armed;

    // Delayed copy of the button plus a one-shot arm flag after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_in_q  <= in;
            r_armed <= 1'b1;
        end
    end

    assign rise = in & ~r_in_q & r_armed;

endmodule

// File: rtl/lock_controller.sv
// Combination lock FSM: collects digits, checks them against the stored code,
// handles code editing, wrong-try counting and the alarm state.
module lock_controller
    import lock_pkg::*;
#(
    parameter int                      DIGITS       = 4,
    parameter int                      MAX_TRIES    = 3,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGIT_W-1:0]  switches,
    input  logic                load,
    input  logic                ok,
    input  logic                admin_button,
    input  logic                timer_done,
    output logic [1:0]          state,
    output logic                timer_start,
    output logic                err,
    output logic [3:0]          fail_cnt,
    output logic [2:0]          digit_idx
);

    // Digit 0 sits in the most significant nibble, hence the ascending range
    typedef logic [0:DIGITS-1][DIGIT_W-1:0] code_t;

    lock_state_e r_state, w_nxt_state;
    logic        r_ts, w_nxt_ts;
    logic        r_err, w_nxt_err;
    logic [3:0]  r_fail, w_nxt_fail;
    logic [2:0]  r_idx, w_nxt_idx;
    code_t       r_entry, w_nxt_entry;
    code_t       r_edit, w_nxt_edit;
    code_t       r_code, w_nxt_code;

    logic        w_load_rise, w_ok_rise, w_adm_rise;
    logic        w_last;
    logic [3:0]  w_fail_inc;

    edge_detect u_ed_load (.clk(clk), .rst_n(rst_n), .in(load),         .rise(w_load_rise));
    edge_detect u_ed_ok   (.clk(clk), .rst_n(rst_n), .in(ok),           .rise(w_ok_rise));
    edge_detect u_ed_adm  (.clk(clk), .rst_n(rst_n), .in(admin_button), .rise(w_adm_rise));

    assign w_last     = (r_idx == 3'(DIGITS-1));
    assign w_fail_inc = (r_fail == 4'hF) ? r_fail : r_fail + 4'd1;

    // Next-state and next-output logic; abort/admin take priority over load
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ts    = 1'b0;
        w_nxt_err   = 1'b0;
        w_nxt_fail  = r_fail;
        w_nxt_idx   = r_idx;
        w_nxt_entry = r_entry;
        w_nxt_edit  = r_edit;
        w_nxt_code  = r_code;
        case (r_state)
            WAITING: begin
                if (w_adm_rise) begin
                    w_nxt_state = EDITING;
                    w_nxt_ts    = 1'b1;
                    w_nxt_idx   = 3'd0;
                end else if (w_load_rise) begin
                    for (int i = 0; i < DIGITS; i++)
                        if (r_idx == 3'(i)) w_nxt_entry[i] = switches;
                    if (w_last) begin
                        w_nxt_idx = 3'd0;
                        if (w_nxt_entry == r_code) begin
                            w_nxt_state = UNLOCKED;
                            w_nxt_ts    = 1'b1;
                            w_nxt_fail  = 4'd0;
                        end else begin
                            w_nxt_err  = 1'b1;
                            w_nxt_fail = w_fail_inc;
                            if (w_fail_inc == 4'(MAX_TRIES)) w_nxt_state = ALARMING;
                        end
                    end else begin
                        w_nxt_idx = r_idx + 3'd1;
                    end
                end
            end
            EDITING: begin
                if (timer_done) begin
                    w_nxt_state = WAITING;
                    w_nxt_idx   = 3'd0;
                    w_nxt_edit  = '0;
                end else if (w_load_rise) begin
                    for (int i = 0; i < DIGITS; i++)
                        if (r_idx == 3'(i)) w_nxt_edit[i] = switches;
                    if (w_last) begin
                        w_nxt_code  = w_nxt_edit;
                        w_nxt_idx   = 3'd0;
                        w_nxt_state = WAITING;
                    end else begin
                        w_nxt_idx = r_idx + 3'd1;
                    end
                end
            end
            UNLOCKED: begin
                if (w_ok_rise || timer_done) w_nxt_state = WAITING;
            end
            ALARMING: begin
                if (w_adm_rise) begin
                    w_nxt_state = WAITING;
                    w_nxt_fail  = 4'd0;
                    w_nxt_idx   = 3'd0;
                end
            end
            default: w_nxt_state = WAITING;
        endcase
    end

    // State, counters, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAITING;
            r_ts    <= 1'b0;
            r_err   <= 1'b0;
            r_fail  <= 4'd0;
            r_idx   <= 3'd0;
            r_entry <= '0;
            r_edit  <= '0;
            r_code  <= code_t'(DEFAULT_CODE);
        end else begin
            r_state <= w_nxt_state;
            r_ts    <= w_nxt_ts;
            r_err   <= w_nxt_err;
            r_fail  <= w_nxt_fail;
            r_idx   <= w_nxt_idx;
            r_entry <= w_nxt_entry;
            r_edit  <= w_nxt_edit;
            r_code  <= w_nxt_code;
        end
    end

    assign state       = r_state;
    assign timer_start = r_ts;
    assign err         = r_err;
    assign fail_cnt    = r_fail;
    assign digit_idx   = r_idx;

endmodule

// File: tb/tb_lock_controller.sv
// Directed table-driven bench for lock_controller with hand-computed vectors,
// followed by a hand-written reset-mid-entry sequence.
module tb_lock_controller;

    localparam logic [1:0] S_W = 2'b00, S_E = 2'b01, S_U = 2'b10, S_A = 2'b11;

    typedef struct {
        logic       ld, ok, adm, td;
        logic [3:0] sw;
        logic [1:0] st;
        logic       ts, er;
        logic [3:0] fc;
        logic [2:0] ix;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] switches = '0;
    logic       load = 1'b0, ok = 1'b0, admin_button = 1'b0, timer_done = 1'b0;
    logic [1:0] state;
    logic       timer_start, err;
    logic [3:0] fail_cnt;
    logic [2:0] digit_idx;

    int total = 0;
    int bad = 0;
    vec_t vq[$];

    lock_controller dut (
        .clk(clk), .rst_n(rst_n), .switches(switches), .load(load), .ok(ok),
        .admin_button(admin_button), .timer_done(timer_done), .state(state),
        .timer_start(timer_start), .err(err), .fail_cnt(fail_cnt), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic ts,
                             input logic er, input logic [3:0] fc, input logic [2:0] ix);
        check({tag, ".state"}, 8'(state), 8'(st));
        check({tag, ".timer_start"}, 8'(timer_start), 8'(ts));
        check({tag, ".err"}, 8'(err), 8'(er));
        check({tag, ".fail_cnt"}, 8'(fail_cnt), 8'(fc));
        check({tag, ".digit_idx"}, 8'(digit_idx), 8'(ix));
    endtask

    task automatic add(input logic ld, input logic okb, input logic adm, input logic td,
                       input logic [3:0] sw, input logic [1:0] st, input logic ts,
                       input logic er, input logic [3:0] fc, input logic [2:0] ix);
        vec_t v;
        v.ld = ld; v.ok = okb; v.adm = adm; v.td = td; v.sw = sw;
        v.st = st; v.ts = ts; v.er = er; v.fc = fc; v.ix = ix;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [1:0] st, input logic [3:0] fc, input logic [2:0] ix);
        add(0, 0, 0, 0, 4'd0, st, 0, 0, fc, ix);
    endtask

    // Four load presses; st0/fc0 hold during entry, st1/ts1/er1/fc1 follow the last digit
    task automatic add_code(input logic [15:0] code, input logic [1:0] st0, input logic [3:0] fc0,
                            input logic [1:0] st1, input logic ts1, input logic er1,
                            input logic [3:0] fc1);
        for (int i = 0; i < 3; i++) begin
            add(1, 0, 0, 0, code[15-4*i -: 4], st0, 0, 0, fc0, 3'(i+1));
            idle(st0, fc0, 3'(i+1));
        end
        add(1, 0, 0, 0, code[3:0], st1, ts1, er1, fc1, 3'd0);
        idle(st1, fc1, 3'd0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        load = v.ld; ok = v.ok; admin_button = v.adm; timer_done = v.td; switches = v.sw;
        @(posedge clk);
        #1;
        check_all(tag, v.st, v.ts, v.er, v.fc, v.ix);
    endtask

    initial begin
        vec_t v;
        // Build the vector table
        idle(S_W, 0, 0);
        add_code(16'h1234, S_W, 0, S_U, 1, 0, 0);
        add(0, 1, 0, 0, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        add_code(16'h1111, S_W, 0, S_W, 0, 1, 1);
        add_code(16'h1111, S_W, 1, S_W, 0, 1, 2);
        add_code(16'h1111, S_W, 2, S_A, 0, 1, 3);
        add(1, 0, 0, 0, 1, S_A, 0, 0, 3, 0); idle(S_A, 3, 0);
        add(0, 0, 0, 1, 0, S_A, 0, 0, 3, 0);
        add(0, 1, 0, 0, 0, S_A, 0, 0, 3, 0); idle(S_A, 3, 0);
        add(0, 0, 1, 0, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        // edit abort keeps 1234
        add(0, 0, 1, 0, 0, S_E, 1, 0, 0, 0); idle(S_E, 0, 0);
        add(1, 0, 0, 0, 5, S_E, 0, 0, 0, 1); idle(S_E, 0, 1);
        add(1, 0, 0, 0, 5, S_E, 0, 0, 0, 2); idle(S_E, 0, 2);
        add(0, 0, 0, 1, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        add_code(16'h1234, S_W, 0, S_U, 1, 0, 0);
        add(0, 1, 0, 0, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        // edit to 9876
        add(0, 0, 1, 0, 0, S_E, 1, 0, 0, 0); idle(S_E, 0, 0);
        add_code(16'h9876, S_E, 0, S_W, 0, 0, 0);
        add_code(16'h1234, S_W, 0, S_W, 0, 1, 1);
        add_code(16'h9876, S_W, 1, S_U, 1, 0, 0);
        // UNLOCKED ignores load/admin; ok+timer_done together
        add(1, 0, 0, 0, 5, S_U, 0, 0, 0, 0); idle(S_U, 0, 0);
        add(0, 0, 1, 0, 0, S_U, 0, 0, 0, 0); idle(S_U, 0, 0);
        add(0, 1, 0, 1, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        add(0, 0, 0, 1, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        // final edit digit with timer_done: abort wins
        add(0, 0, 1, 0, 0, S_E, 1, 0, 0, 0); idle(S_E, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            add(1, 0, 0, 0, 1, S_E, 0, 0, 0, 3'(i)); idle(S_E, 0, 3'(i));
        end
        add(1, 0, 0, 1, 1, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        add_code(16'h9876, S_W, 0, S_U, 1, 0, 0);
        add(0, 0, 0, 1, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        // admin and load together in WAITING: admin wins
        add(1, 0, 1, 0, 1, S_E, 1, 0, 0, 0); idle(S_E, 0, 0);
        add(0, 0, 0, 1, 0, S_W, 0, 0, 0, 0); idle(S_W, 0, 0);
        add_code(16'h1111, S_W, 0, S_W, 0, 1, 1);
        // load held 10 cycles = one digit
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 3, S_W, 0, 0, 1, 1);
        idle(S_W, 1, 1);
        add(1, 0, 0, 0, 2, S_W, 0, 0, 1, 2); idle(S_W, 1, 2);

        // Reset
        #2 rst_n = 1'b0;
        #1 check_all("reset", S_W, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            apply(v, $sformatf("v%0d", i));
        end

        // Reset mid-entry with load held through release; committed 9876 is lost
        @(negedge clk);
        rst_n = 1'b0;
        load = 1'b1; switches = 4'd1;
        #1 check_all("midrst", S_W, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 check_all("held0", S_W, 0, 0, 0, 0);
        @(posedge clk); #1 check_all("held1", S_W, 0, 0, 0, 0);
        vq.delete();
        idle(S_W, 0, 0);
        add_code(16'h1234, S_W, 0, S_U, 1, 0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            apply(v, $sformatf("post%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
